// File: rtl/uart_tx_param.sv
// uart_tx_param -- parametrised serial transmitter.
//
// Sends one DATA_W-bit word per frame in this order: a start bit (0), the
// data bits LSB first, an optional parity bit, then 1 or 2 stop bits (1).
// Every serial bit is held on the line for CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; aborts any frame in flight
//   start_sig  request to send data_in; taken only while ready is high
//   data_in    payload word, sampled only on the accepting edge
//   ready      high only while idle
//   tx         registered serial line, idles high
//   busy       complement of ready
//   done       one-cycle pulse on the final cycle of the last stop bit
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_sig,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              stateQ, stateD;
    logic [BAUD_W-1:0]   baudQ, baudD;
    logic [BIT_W-1:0]    bitQ, bitD;
    logic                stopQ, stopD;
    logic [DATA_W-1:0]   shiftQ, shiftD;
    logic                parityQ, parityD;
    logic                txQ, txD;
    logic                readyQ, readyD;
    logic                busyQ, busyD;
    logic                doneQ, doneD;
    logic                baudLast;

    assign baudLast = (baudQ == BAUD_LAST);

    // Next-state logic. Every state holds its line level for a whole baud
    // period and then moves on, clearing the baud counter. The outputs are
    // derived from the *next* state so that they can be registered and still
    // line up with the state they describe. In particular, done is raised
    // one edge early, so that it is high on the final stop cycle itself.
    always_comb begin
        stateD  = stateQ;
        baudD   = baudQ;
        bitD    = bitQ;
        stopD   = stopQ;
        shiftD  = shiftQ;
        parityD = parityQ;

        case (stateQ)
            IDLE: begin
                if (start_sig) begin
                    shiftD  = data_in;
                    parityD = (^data_in) ^ (PARITY_ODD != 0);
                    baudD   = '0;
                    stateD  = START;
                end
            end
            START: begin
                if (baudLast) begin
                    baudD  = '0;
                    bitD   = '0;
                    stateD = DATA;
                end else begin
                    baudD = baudQ + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baudLast) begin
                    baudD  = '0;
                    shiftD = shiftQ >> 1;
                    if (bitQ == BIT_LAST) begin
                        bitD   = '0;
                        stopD  = 1'b0;
                        stateD = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitD = bitQ + BIT_W'(1);
                    end
                end else begin
                    baudD = baudQ + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (baudLast) begin
                    baudD  = '0;
                    stopD  = 1'b0;
                    stateD = STOP;
                end else begin
                    baudD = baudQ + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baudLast) begin
                    baudD = '0;
                    if (stopQ == STOP_LAST) begin
                        stateD = IDLE;
                    end else begin
                        stopD = 1'b1;
                    end
                end else begin
                    baudD = baudQ + BAUD_W'(1);
                end
            end
            default: begin
                stateD = IDLE;
                baudD  = '0;
            end
        endcase

        case (stateD)
            START:   txD = 1'b0;
            DATA:    txD = shiftD[0];
            PARITY:  txD = parityD;
            default: txD = 1'b1;
        endcase

        readyD = (stateD == IDLE);
        busyD  = (stateD != IDLE);
        doneD  = (stateD == STOP) && (baudD == BAUD_LAST) && (stopD == STOP_LAST);
    end

    // Register the whole machine. A reset takes effect from any state,
    // so a frame that is in flight is simply dropped, without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            baudQ   <= '0;
            bitQ    <= '0;
            stopQ   <= 1'b0;
            shiftQ  <= '0;
            parityQ <= 1'b0;
            txQ     <= 1'b1;
            readyQ  <= 1'b1;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            baudQ   <= baudD;
            bitQ    <= bitD;
            stopQ   <= stopD;
            shiftQ  <= shiftD;
            parityQ <= parityD;
            txQ     <= txD;
            readyQ  <= readyD;
            busyQ   <= busyD;
            doneQ   <= doneD;
        end
    end

    assign tx    = txQ;
    assign ready = readyQ;
    assign busy  = busyQ;
    assign done  = doneQ;

endmodule
